// File: rtl/morra_pkg.sv
// Shared codes for the MorraCinese stimulus driver: move, round and match
// encodings plus the driver state enum.
package morra_pkg;

  localparam logic [1:0] MOVE_NONE    = 2'b00;
  localparam logic [1:0] MOVE_SASSO   = 2'b01;
  localparam logic [1:0] MOVE_CARTA   = 2'b10;
  localparam logic [1:0] MOVE_FORBICE = 2'b11;

  localparam logic [1:0] MANCHE_INVALID  = 2'b00;
  localparam logic [1:0] MANCHE_PRIMO    = 2'b01;
  localparam logic [1:0] MANCHE_SECONDO  = 2'b10;
  localparam logic [1:0] MANCHE_PAREGGIO = 2'b11;

  localparam logic [1:0] PARTITA_RUNNING  = 2'b00;
  localparam logic [1:0] PARTITA_PRIMO    = 2'b01;
  localparam logic [1:0] PARTITA_SECONDO  = 2'b10;
  localparam logic [1:0] PARTITA_PAREGGIO = 2'b11;

  localparam logic [4:0] IDX_MAX = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESULT = 3'd4,
    ST_OVER   = 3'd5
  } drv_state_e;

endpackage

// File: rtl/morra_driver_if.sv
// Host-side command and result streams of the MorraCinese driver.
// Both streams: a beat transfers on a rising edge where VALID and READY are
// both 1; a source holds VALID and its payload stable until that edge.
interface morra_driver_if;

  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_START;
  logic [1:0] CMD_PRIMO;
  logic [1:0] CMD_SECONDO;

  logic       RES_VALID;
  logic       RES_READY;
  logic [1:0] RES_MANCHE;
  logic [1:0] RES_PARTITA;
  logic [4:0] RES_IDX;
  logic       RES_ERR;

  modport master (
    output CMD_VALID, CMD_START, CMD_PRIMO, CMD_SECONDO, RES_READY,
    input  CMD_READY, RES_VALID, RES_MANCHE, RES_PARTITA, RES_IDX, RES_ERR
  );

  modport slave (
    input  CMD_VALID, CMD_START, CMD_PRIMO, CMD_SECONDO, RES_READY,
    output CMD_READY, RES_VALID, RES_MANCHE, RES_PARTITA, RES_IDX, RES_ERR
  );

endinterface

// File: rtl/morra_driver.sv
// Command-driven stimulus engine for the MorraCinese game: one round in flight,
// registered game inputs, results captured into a valid/ready record stream.
module morra_driver
  import morra_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  morra_driver_if.slave  host,
  output logic           INIZIO,
  output logic [1:0]     PRIMO,
  output logic [1:0]     SECONDO,
  input  logic [1:0]     MANCHE,
  input  logic [1:0]     PARTITA,
  output logic           BUSY,
  output drv_state_e     state_o
);

  drv_state_e state_q, state_d;
  logic       inizio_q, inizio_d;
  logic [1:0] primo_q, primo_d;
  logic [1:0] secondo_q, secondo_d;
  logic [1:0] manche_q, manche_d;
  logic [1:0] partita_q, partita_d;
  logic [4:0] idx_q, idx_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       move_q, move_d;
  logic       rej_q, rej_d;
  logic       cmd_ready;
  logic       cmd_fire;

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_ARMED) || (state_q == ST_OVER);
  assign cmd_fire  = host.CMD_VALID && cmd_ready;

  always_comb begin
    state_d   = state_q;
    inizio_d  = 1'b0;
    primo_d   = MOVE_NONE;
    secondo_d = MOVE_NONE;
    manche_d  = manche_q;
    partita_d = partita_q;
    idx_d     = idx_q;
    err_d     = err_q;
    busy_d    = busy_q;
    move_d    = move_q;
    rej_d     = rej_q;

    case (state_q)
      ST_IDLE, ST_ARMED, ST_OVER: begin
        if (cmd_fire) begin
          if (host.CMD_START) begin
            state_d   = ST_DRIVE;
            inizio_d  = 1'b1;
            primo_d   = host.CMD_PRIMO;
            secondo_d = host.CMD_SECONDO;
            idx_d     = 5'd0;
            busy_d    = 1'b1;
            move_d    = 1'b0;
            rej_d     = 1'b0;
          end else if (state_q == ST_ARMED) begin
            state_d   = ST_DRIVE;
            primo_d   = host.CMD_PRIMO;
            secondo_d = host.CMD_SECONDO;
            move_d    = 1'b1;
            rej_d     = 1'b0;
          end else begin
            // Rejected moves skip DRIVE but still spend one cycle in SAMPLE,
            // so the error record appears one cycle after acceptance.
            state_d = ST_SAMPLE;
            rej_d   = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        state_d = ST_RESULT;
        if (rej_q) begin
          manche_d  = MANCHE_INVALID;
          partita_d = PARTITA_RUNNING;
          err_d     = 1'b1;
        end else begin
          manche_d  = MANCHE;
          partita_d = PARTITA;
          err_d     = 1'b0;
          if (move_q && (MANCHE != MANCHE_INVALID) && (idx_q != IDX_MAX)) begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ST_RESULT: begin
        if (host.RES_READY) begin
          if (partita_q != PARTITA_RUNNING) begin
            state_d = ST_OVER;
            busy_d  = 1'b0;
          end else if (busy_q) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      inizio_q  <= 1'b0;
      primo_q   <= MOVE_NONE;
      secondo_q <= MOVE_NONE;
      manche_q  <= MANCHE_INVALID;
      partita_q <= PARTITA_RUNNING;
      idx_q     <= 5'd0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      move_q    <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      inizio_q  <= inizio_d;
      primo_q   <= primo_d;
      secondo_q <= secondo_d;
      manche_q  <= manche_d;
      partita_q <= partita_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      move_q    <= move_d;
      rej_q     <= rej_d;
    end
  end

  assign host.CMD_READY   = cmd_ready;
  assign host.RES_VALID   = (state_q == ST_RESULT);
  assign host.RES_MANCHE  = manche_q;
  assign host.RES_PARTITA = partita_q;
  assign host.RES_IDX     = idx_q;
  assign host.RES_ERR     = err_q;

  assign INIZIO  = inizio_q;
  assign PRIMO   = primo_q;
  assign SECONDO = secondo_q;
  assign BUSY    = busy_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_morra_driver.sv
// Bench for morra_driver: a behavioural MorraCinese game closes the loop and a
// per-command reference model predicts every result record.
module tb_morra_driver;
  import morra_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inizio;
  logic [1:0] primo, secondo;
  logic [1:0] manche, partita;
  logic       busy;
  drv_state_e dbg_state;

  morra_driver_if bus();

  morra_driver dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (bus),
    .INIZIO  (inizio),
    .PRIMO   (primo),
    .SECONDO (secondo),
    .MANCHE  (manche),
    .PARTITA (partita),
    .BUSY    (busy),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- game rules ----------------
  function automatic logic [1:0] rps(input logic [1:0] a, input logic [1:0] b);
    if (a == b) return MANCHE_PAREGGIO;
    if ((a == MOVE_SASSO && b == MOVE_FORBICE) || (a == MOVE_CARTA && b == MOVE_SASSO) ||
        (a == MOVE_FORBICE && b == MOVE_CARTA)) return MANCHE_PRIMO;
    return MANCHE_SECONDO;
  endfunction

  function automatic logic [1:0] decide(input int s1, input int s2, input int played, input int mx);
    if (s1 - s2 >= 2) return PARTITA_PRIMO;
    if (s2 - s1 >= 2) return PARTITA_SECONDO;
    if (played >= mx) begin
      if (s1 > s2) return PARTITA_PRIMO;
      if (s2 > s1) return PARTITA_SECONDO;
      return PARTITA_PAREGGIO;
    end
    return PARTITA_RUNNING;
  endfunction

  // Cycle-level game core: start config {PRIMO,SECONDO}+4 rounds, lead of 2 wins.
  logic g_on;
  int   g_s1, g_s2, g_played, g_max;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_on <= 1'b0; g_s1 <= 0; g_s2 <= 0; g_played <= 0; g_max <= 0;
      manche <= MANCHE_INVALID; partita <= PARTITA_RUNNING;
    end else if (inizio) begin
      g_on <= 1'b1; g_s1 <= 0; g_s2 <= 0; g_played <= 0;
      g_max <= int'({primo, secondo}) + 4;
      manche <= MANCHE_INVALID; partita <= PARTITA_RUNNING;
    end else if (g_on && partita == PARTITA_RUNNING && primo != MOVE_NONE && secondo != MOVE_NONE) begin
      manche   <= rps(primo, secondo);
      g_s1     <= g_s1 + ((rps(primo, secondo) == MANCHE_PRIMO) ? 1 : 0);
      g_s2     <= g_s2 + ((rps(primo, secondo) == MANCHE_SECONDO) ? 1 : 0);
      g_played <= g_played + 1;
      partita  <= decide(g_s1 + ((rps(primo, secondo) == MANCHE_PRIMO) ? 1 : 0),
                         g_s2 + ((rps(primo, secondo) == MANCHE_SECONDO) ? 1 : 0),
                         g_played + 1, g_max);
    end else begin
      manche <= MANCHE_INVALID;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one step per command, tracking match score and round count.
  bit m_busy, m_over;
  int m_idx, m_s1, m_s2, m_played, m_max;

  task automatic model_reset();
    m_busy = 0; m_over = 0; m_idx = 0;
    m_s1 = 0; m_s2 = 0; m_played = 0; m_max = 0;
    exp_q.delete();
  endtask

  task automatic model_cmd(input bit st, input logic [1:0] p, input logic [1:0] s,
                           output bit rej, output bit busy_res);
    logic [1:0] mm, pp;
    rej = 0; mm = MANCHE_INVALID; pp = PARTITA_RUNNING;
    if (st) begin
      m_busy = 1; m_over = 0; m_idx = 0;
      m_s1 = 0; m_s2 = 0; m_played = 0; m_max = int'({p, s}) + 4;
    end else if (!m_busy) begin
      rej = 1; m_over = 0;
    end else if (p != MOVE_NONE && s != MOVE_NONE) begin
      mm = rps(p, s);
      if (mm == MANCHE_PRIMO) m_s1++;
      if (mm == MANCHE_SECONDO) m_s2++;
      m_played++;
      pp = decide(m_s1, m_s2, m_played, m_max);
      if (m_idx < 31) m_idx++;
    end
    exp_q.push_back({rej, mm, pp, 5'(m_idx)});
    busy_res = m_busy;
    if (pp != PARTITA_RUNNING) begin
      m_busy = 0; m_over = 1;
    end
  endtask

  function automatic drv_state_e model_state();
    if (m_over) return ST_OVER;
    if (m_busy) return ST_ARMED;
    return ST_IDLE;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input bit st, input logic [1:0] p, input logic [1:0] s, input int hold);
    bit rej, busy_res;
    int n;
    logic [9:0] exp_rec;
    @(negedge clk);
    bus.CMD_VALID = 1'b1; bus.CMD_START = st; bus.CMD_PRIMO = p; bus.CMD_SECONDO = s;
    check("cmd_ready", bus.CMD_READY, 1'b1);
    model_cmd(st, p, s, rej, busy_res);
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b0;
    check("ready_low", bus.CMD_READY, 1'b0);
    check("drive_pat", {inizio, primo, secondo}, rej ? 5'b0 : {st, p, s});
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) check("idle_pat", {inizio, primo, secondo}, 5'b0);
    end while (!bus.RES_VALID && n < 10);
    check("res_latency", n, rej ? 1 : 2);
    exp_rec = exp_q.pop_front();
    check("res_rec", {bus.RES_ERR, bus.RES_MANCHE, bus.RES_PARTITA, bus.RES_IDX}, exp_rec);
    check("busy_res", busy, busy_res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rec", {bus.RES_VALID, bus.RES_ERR, bus.RES_MANCHE, bus.RES_PARTITA, bus.RES_IDX},
            {1'b1, exp_rec});
      check("hold_ready", bus.CMD_READY, 1'b0);
      check("hold_pat", {inizio, primo, secondo}, 5'b0);
    end
    @(negedge clk);
    bus.RES_READY = 1'b1;
    @(posedge clk); #1;
    bus.RES_READY = 1'b0;
    check("res_drop", bus.RES_VALID, 1'b0);
    check("busy_after", busy, m_busy);
    check("state_after", dbg_state, model_state());
    check("ready_after", bus.CMD_READY, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit st;
    logic [1:0] p, s;
    int guard;
    bus.CMD_VALID = 0; bus.CMD_START = 0; bus.CMD_PRIMO = 0; bus.CMD_SECONDO = 0;
    bus.RES_READY = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pat", {inizio, primo, secondo}, 5'b0);
    check("rst_res", {bus.RES_VALID, bus.RES_ERR, bus.RES_MANCHE, bus.RES_PARTITA, bus.RES_IDX}, 11'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.CMD_READY, 1'b1);

    // Stray RES_READY with nothing pending is ignored.
    bus.RES_READY = 1'b1;
    repeat (2) @(negedge clk);
    bus.RES_READY = 1'b0;
    check("stray_ready", {bus.RES_VALID, 3'(dbg_state)}, {1'b0, 3'(ST_IDLE)});

    send_cmd(1'b0, MOVE_SASSO, MOVE_CARTA, 0);     // rejected in IDLE
    send_cmd(1'b1, MOVE_NONE, MOVE_NONE, 0);       // start, 4 rounds
    send_cmd(1'b0, MOVE_CARTA, MOVE_SASSO, 0);     // primo wins, idx 1
    send_cmd(1'b0, MOVE_NONE, MOVE_CARTA, 0);      // invalid round, idx stays
    guard = 0;
    while (m_busy && guard < 20) begin
      send_cmd(1'b0, MOVE_SASSO, MOVE_CARTA, 0);
      guard++;
    end
    check("over_partita", bus.RES_PARTITA, PARTITA_SECONDO);
    check("over_state", dbg_state, ST_OVER);
    send_cmd(1'b0, MOVE_CARTA, MOVE_CARTA, 0);     // rejected after match decided
    send_cmd(1'b1, MOVE_SASSO, MOVE_NONE, 5);      // new start, held result
    check("restart_idx", bus.RES_IDX, 5'd0);

    // Reset while the move 11/01 is being driven.
    @(negedge clk);
    bus.CMD_VALID = 1'b1; bus.CMD_START = 1'b0;
    bus.CMD_PRIMO = MOVE_FORBICE; bus.CMD_SECONDO = MOVE_SASSO;
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b0;
    check("abort_drive", {inizio, primo, secondo}, {1'b0, MOVE_FORBICE, MOVE_SASSO});
    rst_n = 1'b0;
    #1;
    check("abort_pat", {inizio, primo, secondo}, 5'b0);
    check("abort_valid", bus.RES_VALID, 1'b0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_busy", busy, 1'b0);

    // Randomised command mix.
    for (int i = 0; i < 80; i++) begin
      st = ($urandom_range(0, 9) < 2);
      p  = 2'($urandom_range(0, 3));
      s  = 2'($urandom_range(0, 3));
      if (!st && p == MOVE_NONE && $urandom_range(0, 1) == 1) p = MOVE_CARTA;
      send_cmd(st, p, s, $urandom_range(0, 2));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
